// File: rtl/nikhilam_pkg.sv
// Shared widths and state encoding for the nikhilam multiply-accumulate slice.
package nikhilam_pkg;

  localparam int unsigned OP_W   = 4;
  localparam int unsigned PROD_W = 8;

  typedef enum logic {
    S_ACC  = 1'b0,
    S_HOLD = 1'b1
  } mac_state_t;

endpackage : nikhilam_pkg

// File: rtl/nikhilam_mac_nikhilum.sv
// nikhilum: 4x4 unsigned multiplier using the Nikhilam method with base 16.
// a*b = (a + b - 16)*16 + (16-a)*(16-b). The 4-bit complement wraps for a zero
// operand, so a zero input gives a wrong product; callers must handle that case.
module nikhilum
  import nikhilam_pkg::*;
(
  input  logic [OP_W-1:0]   a,
  input  logic [OP_W-1:0]   b,
  output logic [PROD_W-1:0] p
);

  logic [OP_W-1:0] ca;
  logic [OP_W-1:0] cb;
  logic [OP_W:0]   s;

  // Complements from the base, cross-sum, then recombine modulo 2^PROD_W
  always_comb begin
    ca = OP_W'(5'd16 - 5'(a));
    cb = OP_W'(5'd16 - 5'(b));
    s  = 5'(a) + 5'(b);
    p  = {s[OP_W-1:0], 4'b0000} + (PROD_W'(ca) * PROD_W'(cb));
  end

endmodule : nikhilum

// File: rtl/nikhilam_mac.sv
// nikhilam_mac: streaming multiply-accumulate over packets of 4-bit pairs.
// Stage 1 registers an accepted pair, stage 2 adds its product to the
// accumulator; the pair marked last closes the packet and the result is held
// until the consumer takes it.
// Optional macro SATURATE_EN: clamp the accumulator at all-ones and report a
// sticky overflow on out_ovf; otherwise accumulation wraps and out_ovf is 0.
module nikhilam_mac
  import nikhilam_pkg::*;
#(
  parameter int unsigned ACC_W = 16,
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [OP_W-1:0]  in_a,
  input  logic [OP_W-1:0]  in_b,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_sum,
  output logic [CNT_W-1:0] out_count,
  output logic             out_ovf
);

  mac_state_t state_q, state_d;

  logic             in_ready_q, in_ready_d;
  logic             s1_valid_q, s1_valid_d;
  logic [OP_W-1:0]  a_q, a_d;
  logic [OP_W-1:0]  b_q, b_d;
  logic             last_q, last_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             out_valid_q, out_valid_d;
  logic [ACC_W-1:0] out_sum_q, out_sum_d;
  logic [CNT_W-1:0] out_count_q, out_count_d;

  logic              accept_c;
  logic [PROD_W-1:0] prod_raw_c;
  logic [ACC_W-1:0]  prod_c;
  logic [ACC_W-1:0]  sum_c;
  logic [CNT_W-1:0]  cnt_inc_c;

`ifdef SATURATE_EN
  localparam int unsigned SUM_W = ACC_W + 1;
  logic             ovf_q, ovf_d;
  logic             out_ovf_q, out_ovf_d;
  logic [SUM_W-1:0] sum_ext_c;
  logic             carry_c;
`endif

  nikhilum u_mul (
    .a (a_q),
    .b (b_q),
    .p (prod_raw_c)
  );

  // Handshake, zero-operand fix, accumulate add and saturating pair count
  always_comb begin
    accept_c  = in_valid && in_ready_q;
    prod_c    = ((a_q == '0) || (b_q == '0)) ? '0 : ACC_W'(prod_raw_c);
    cnt_inc_c = (&cnt_q) ? cnt_q : cnt_q + CNT_W'(1);
`ifdef SATURATE_EN
    sum_ext_c = SUM_W'(acc_q) + SUM_W'(prod_c);
    carry_c   = sum_ext_c[ACC_W];
    sum_c     = carry_c ? '1 : sum_ext_c[ACC_W-1:0];
`else
    sum_c     = acc_q + prod_c;
`endif
  end

  // State and pipeline registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_ACC;
      in_ready_q  <= 1'b0;
      s1_valid_q  <= 1'b0;
      a_q         <= '0;
      b_q         <= '0;
      last_q      <= 1'b0;
      acc_q       <= '0;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
      out_sum_q   <= '0;
      out_count_q <= '0;
`ifdef SATURATE_EN
      ovf_q       <= 1'b0;
      out_ovf_q   <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      in_ready_q  <= in_ready_d;
      s1_valid_q  <= s1_valid_d;
      a_q         <= a_d;
      b_q         <= b_d;
      last_q      <= last_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      out_valid_q <= out_valid_d;
      out_sum_q   <= out_sum_d;
      out_count_q <= out_count_d;
`ifdef SATURATE_EN
      ovf_q       <= ovf_d;
      out_ovf_q   <= out_ovf_d;
`endif
    end
  end

  // Next state: close packet on a staged last pair, reopen on result handoff
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_ACC:  if (s1_valid_q && last_q) state_d = S_HOLD;
      S_HOLD: if (out_valid_q && out_ready) state_d = S_ACC;
      default: state_d = S_ACC;
    endcase
  end

  // Datapath and output register updates
  always_comb begin
    s1_valid_d  = accept_c;
    a_d         = a_q;
    b_d         = b_q;
    last_d      = last_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    out_valid_d = out_valid_q;
    out_sum_d   = out_sum_q;
    out_count_d = out_count_q;
`ifdef SATURATE_EN
    ovf_d       = ovf_q;
    out_ovf_d   = out_ovf_q;
`endif

    if (accept_c) begin
      a_d    = in_a;
      b_d    = in_b;
      last_d = in_last;
    end

    if (s1_valid_q) begin
      if (!last_q) begin
        acc_d = sum_c;
        cnt_d = cnt_inc_c;
`ifdef SATURATE_EN
        ovf_d = ovf_q || carry_c;
`endif
      end else begin
        out_sum_d   = sum_c;
        out_count_d = cnt_inc_c;
        out_valid_d = 1'b1;
        acc_d       = '0;
        cnt_d       = '0;
`ifdef SATURATE_EN
        out_ovf_d   = ovf_q || carry_c;
        ovf_d       = 1'b0;
`endif
      end
    end

    if ((state_q == S_HOLD) && out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end

    // Registered form of: ready in S_ACC unless a last pair is staged
    in_ready_d = (state_d == S_ACC) && !(s1_valid_d && last_d);
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_sum   = out_sum_q;
  assign out_count = out_count_q;
`ifdef SATURATE_EN
  assign out_ovf   = out_ovf_q;
`else
  assign out_ovf   = 1'b0;
`endif

endmodule : nikhilam_mac

// File: tb/tb_nikhilam_mac.sv
// Directed bench for nikhilam_mac built with ACC_W=8 so overflow is reachable.
module tb_nikhilam_mac;

  localparam int unsigned ACC_W = 8;
  localparam int unsigned CNT_W = 8;

  logic             clk;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [3:0]       in_a;
  logic [3:0]       in_b;
  logic             in_last;
  logic             out_valid;
  logic             out_ready;
  logic [ACC_W-1:0] out_sum;
  logic [CNT_W-1:0] out_count;
  logic             out_ovf;

  int checks   = 0;
  int failures = 0;

  nikhilam_mac #(.ACC_W(ACC_W), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_count (out_count),
    .out_ovf   (out_ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one pair and hold it until it is accepted (bounded)
  task automatic send_pair(input logic [3:0] a, input logic [3:0] b, input logic last);
    int n;
    in_valid = 1'b1;
    in_a     = a;
    in_b     = b;
    in_last  = last;
    n = 0;
    while (!in_ready && n < 50) begin
      tick();
      n++;
    end
    checks++;
    if (!in_ready) begin
      failures++;
      $display("FAIL send_timeout: in_ready=%0b required=1", in_ready);
    end
    tick();
    in_valid = 1'b0;
    in_a     = 4'd0;
    in_b     = 4'd0;
    in_last  = 1'b0;
  endtask

  // Wait (bounded) for a packet result to appear
  task automatic wait_out();
    int n;
    n = 0;
    while (!out_valid && n < 50) begin
      tick();
      n++;
    end
    checks++;
    if (!out_valid) begin
      failures++;
      $display("FAIL out_timeout: out_valid=%0b required=1", out_valid);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) tick();
    checks++;
    if ({in_ready, out_valid, out_ovf} !== 3'b000 || out_sum !== '0 || out_count !== '0) begin
      failures++;
      $display("FAIL reset_outputs: rdy=%0b vld=%0b sum=%0d cnt=%0d ovf=%0b required all 0",
               in_ready, out_valid, out_sum, out_count, out_ovf);
    end
    rst = 1'b0;
    tick();
    checks++;
    if (in_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_release_ready: in_ready=%0b required=1", in_ready);
    end
  endtask

  task automatic test_basic();
    out_ready = 1'b1;
    send_pair(4'd3, 4'd5, 1'b0);
    send_pair(4'd15, 4'd15, 1'b0);
    send_pair(4'd1, 4'd1, 1'b1);
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b0) begin
      failures++;
      $display("FAIL basic_stage1: out_valid=%0b in_ready=%0b required 0 0", out_valid, in_ready);
    end
    tick();
    checks++;
    if (out_valid !== 1'b1 || out_sum !== 8'd241 || out_count !== 8'd3) begin
      failures++;
      $display("FAIL basic_result: vld=%0b sum=%0d cnt=%0d required 1 241 3",
               out_valid, out_sum, out_count);
    end
    tick();
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      failures++;
      $display("FAIL basic_pulse: vld=%0b rdy=%0b required 0 1", out_valid, in_ready);
    end
  endtask

  task automatic test_zero_operand();
    out_ready = 1'b1;
    send_pair(4'd0, 4'd7, 1'b0);
    send_pair(4'd9, 4'd0, 1'b1);
    wait_out();
    checks++;
    if (out_sum !== 8'd0 || out_count !== 8'd2) begin
      failures++;
      $display("FAIL zero_operand: sum=%0d cnt=%0d required 0 2", out_sum, out_count);
    end
    tick();
  endtask

  task automatic test_hold();
    out_ready = 1'b0;
    send_pair(4'd12, 4'd12, 1'b1);
    wait_out();
    // Junk presented during hold must be ignored
    in_valid = 1'b1;
    in_a     = 4'd7;
    in_b     = 4'd7;
    in_last  = 1'b1;
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (out_valid !== 1'b1 || out_sum !== 8'd144 || out_count !== 8'd1 || in_ready !== 1'b0) begin
        failures++;
        $display("FAIL hold_cycle%0d: vld=%0b sum=%0d cnt=%0d rdy=%0b required 1 144 1 0",
                 i, out_valid, out_sum, out_count, in_ready);
      end
      tick();
    end
    out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    in_last  = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      failures++;
      $display("FAIL hold_release: vld=%0b rdy=%0b required 0 1", out_valid, in_ready);
    end
    repeat (3) tick();
    checks++;
    if (out_valid !== 1'b0) begin
      failures++;
      $display("FAIL hold_junk_ignored: out_valid=%0b required=0", out_valid);
    end
  endtask

  task automatic test_overflow();
    logic [7:0] exp_sum;
    logic       exp_ovf;
`ifdef SATURATE_EN
    exp_sum = 8'd255;
    exp_ovf = 1'b1;
`else
    exp_sum = 8'd194;
    exp_ovf = 1'b0;
`endif
    out_ready = 1'b1;
    send_pair(4'd15, 4'd15, 1'b0);
    send_pair(4'd15, 4'd15, 1'b1);
    wait_out();
    checks++;
    if (out_sum !== exp_sum || out_ovf !== exp_ovf || out_count !== 8'd2) begin
      failures++;
      $display("FAIL overflow: sum=%0d ovf=%0b cnt=%0d required %0d %0b 2",
               out_sum, out_ovf, out_count, exp_sum, exp_ovf);
    end
    tick();
    send_pair(4'd1, 4'd1, 1'b1);
    wait_out();
    checks++;
    if (out_sum !== 8'd1 || out_ovf !== 1'b0 || out_count !== 8'd1) begin
      failures++;
      $display("FAIL overflow_clear: sum=%0d ovf=%0b cnt=%0d required 1 0 1",
               out_sum, out_ovf, out_count);
    end
    tick();
  endtask

  task automatic test_reset_mid_packet();
    out_ready = 1'b1;
    send_pair(4'd10, 4'd10, 1'b0);
    send_pair(4'd2, 4'd3, 1'b0);
    rst = 1'b1;
    #1;
    checks++;
    if ({in_ready, out_valid, out_ovf} !== 3'b000 || out_sum !== '0 || out_count !== '0) begin
      failures++;
      $display("FAIL midreset_outputs: rdy=%0b vld=%0b sum=%0d cnt=%0d ovf=%0b required all 0",
               in_ready, out_valid, out_sum, out_count, out_ovf);
    end
    tick();
    tick();
    rst = 1'b0;
    tick();
    send_pair(4'd4, 4'd4, 1'b1);
    wait_out();
    checks++;
    if (out_sum !== 8'd16 || out_count !== 8'd1) begin
      failures++;
      $display("FAIL midreset_packet: sum=%0d cnt=%0d required 16 1", out_sum, out_count);
    end
    tick();
  endtask

  task automatic test_back_to_back();
    logic [3:0] ta [7];
    logic [3:0] tb [7];
    logic       tl [7];
    int         exp_sum [$];
    int         exp_cnt [$];
    int         acc, cnt, idx, got, cyc;
    logic       accepted;
    ta = '{4'd2, 4'd4, 4'd6, 4'd8, 4'd1, 4'd0, 4'd3};
    tb = '{4'd3, 4'd5, 4'd7, 4'd8, 4'd15, 4'd9, 4'd3};
    tl = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
    acc = 0;
    cnt = 0;
    for (int i = 0; i < 7; i++) begin
      acc = acc + int'(ta[i]) * int'(tb[i]);
      cnt++;
      if (tl[i]) begin
`ifdef SATURATE_EN
        exp_sum.push_back(acc > 255 ? 255 : acc);
`else
        exp_sum.push_back(acc % 256);
`endif
        exp_cnt.push_back(cnt);
        acc = 0;
        cnt = 0;
      end
    end
    out_ready = 1'b1;
    idx = 0;
    got = 0;
    cyc = 0;
    in_valid = 1'b1;
    while ((idx < 7 || got < exp_sum.size()) && cyc < 200) begin
      if (idx < 7) begin
        in_a    = ta[idx];
        in_b    = tb[idx];
        in_last = tl[idx];
      end else begin
        in_a    = 4'd0;
        in_b    = 4'd0;
        in_last = 1'b0;
      end
      accepted = in_ready && (idx < 7);
      tick();
      cyc++;
      if (accepted) begin
        if (tl[idx]) begin
          checks++;
          if (in_ready !== 1'b0) begin
            failures++;
            $display("FAIL b2b_ready_drop: pair %0d in_ready=%0b required=0", idx, in_ready);
          end
        end
        idx++;
        if (idx == 7) in_valid = 1'b0;
      end
      if (out_valid === 1'b1) begin
        checks++;
        if (got >= exp_sum.size()) begin
          failures++;
          $display("FAIL b2b_extra_result: sum=%0d cnt=%0d required none", out_sum, out_count);
        end else if (int'(out_sum) != exp_sum[got] || int'(out_count) != exp_cnt[got]) begin
          failures++;
          $display("FAIL b2b_packet%0d: sum=%0d cnt=%0d required %0d %0d",
                   got, out_sum, out_count, exp_sum[got], exp_cnt[got]);
        end
        got++;
      end
    end
    in_valid = 1'b0;
    checks++;
    if (idx != 7 || got != exp_sum.size()) begin
      failures++;
      $display("FAIL b2b_complete: pairs=%0d packets=%0d required 7 %0d", idx, got, exp_sum.size());
    end
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_a      = 4'd0;
    in_b      = 4'd0;
    in_last   = 1'b0;
    out_ready = 1'b0;
    test_reset();
    test_basic();
    test_zero_operand();
    test_hold();
    test_overflow();
    test_reset_mid_packet();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_nikhilam_mac
